// File: rtl/mult_pkg.sv
// Shared constants, operand bundle and partial-product helper for the shared multiply tree.
package mult_pkg;

    localparam int OPND_W  = 4;
    localparam int PART_W  = 12;
    localparam int PROD_W  = 24;
    localparam int RES_W   = 8;
    localparam int RES_MSB = 23;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] c;
        logic [OPND_W-1:0] d;
    } mult_opnd_t;

    // x*y*y fits in PART_W bits for 4-bit operands (15^3 = 3375)
    function automatic logic [PART_W-1:0] mul_xyy(input logic [OPND_W-1:0] x,
                                                  input logic [OPND_W-1:0] y);
        return PART_W'(x) * PART_W'(y) * PART_W'(y);
    endfunction

endpackage

// File: rtl/mult_tree_pipe.sv
// Three-stage multiply tree ((a*b*b)*(c*d*d)) returning the top result byte, with valid/ID sideband.
module mult_tree_pipe
    import mult_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [ID_W-1:0]  in_id_i,
    input  mult_opnd_t       in_opnd_i,
    output logic             out_valid_o,
    output logic [ID_W-1:0]  out_id_o,
    output logic [RES_W-1:0] out_res_o,
    output logic             busy_o
);

    logic              s1_valid_q;
    logic [ID_W-1:0]   s1_id_q;
    mult_opnd_t        s1_opnd_q;
    logic              s2_valid_q;
    logic [ID_W-1:0]   s2_id_q;
    logic [PART_W-1:0] s2_abb_q;
    logic [PART_W-1:0] s2_cdd_q;
    logic              s3_valid_q;
    logic [ID_W-1:0]   s3_id_q;
    logic [RES_W-1:0]  s3_res_q;
    logic [PROD_W-1:0] prod_d;

    // Full product formed between S2 and S3; only its top byte is kept
    always_comb begin
        prod_d = PROD_W'(s2_abb_q) * PROD_W'(s2_cdd_q);
    end

    // Stage registers; data regs load only with a valid op so idle stages stay quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_opnd_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_abb_q   <= '0;
            s2_cdd_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_id_q    <= '0;
            s3_res_q   <= '0;
        end else begin
            s1_valid_q <= in_valid_i;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            if (in_valid_i) begin
                s1_id_q   <= in_id_i;
                s1_opnd_q <= in_opnd_i;
            end
            if (s1_valid_q) begin
                s2_id_q  <= s1_id_q;
                s2_abb_q <= mul_xyy(s1_opnd_q.a, s1_opnd_q.b);
                s2_cdd_q <= mul_xyy(s1_opnd_q.c, s1_opnd_q.d);
            end
            if (s2_valid_q) begin
                s3_id_q  <= s2_id_q;
                s3_res_q <= prod_d[RES_MSB -: RES_W];
            end
        end
    end

    assign out_valid_o = s3_valid_q;
    assign out_id_o    = s3_id_q;
    assign out_res_o   = s3_res_q;
    assign busy_o      = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: rtl/mult_tree_arbiter.sv
// Round-robin arbiter sharing one pipelined multiply tree among N_REQ requesters.
// Optional per-requester saturating grant counters are built when MULT_ARB_STATS_EN is defined.
module mult_tree_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [OPND_W*N_REQ-1:0] req_a,
    input  logic [OPND_W*N_REQ-1:0] req_b,
    input  logic [OPND_W*N_REQ-1:0] req_c,
    input  logic [OPND_W*N_REQ-1:0] req_d,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_result,
    output logic                    busy
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]     grant_cnt
`endif
);

    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic             grant_found_s;
    logic [ID_W-1:0]  grant_id_s;
    mult_opnd_t       grant_opnd_s;
    logic             pipe_valid_s;
    logic [ID_W-1:0]  pipe_id_s;
    logic [RES_W-1:0] pipe_res_s;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [N_REQ-1:0] rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q;
    logic [RES_W-1:0] rsp_result_q;

    // Search starts at rr_ptr and wraps modulo N_REQ; first valid requester wins
    always_comb begin : arb_search
        logic [ID_W:0] cand;
        cand          = '0;
        grant_found_s = 1'b0;
        grant_id_s    = rr_ptr_q;
        for (int j = 0; j < N_REQ; j++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(j);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end else begin
                cand = cand;
            end
            if (en && !grant_found_s && req_valid[cand[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot ready, operand mux and pointer advance for the granted requester
    always_comb begin
        req_ready        = '0;
        grant_opnd_s.a   = req_a[{grant_id_s, 2'b00} +: OPND_W];
        grant_opnd_s.b   = req_b[{grant_id_s, 2'b00} +: OPND_W];
        grant_opnd_s.c   = req_c[{grant_id_s, 2'b00} +: OPND_W];
        grant_opnd_s.d   = req_d[{grant_id_s, 2'b00} +: OPND_W];
        rr_ptr_d         = rr_ptr_q;
        if (grant_found_s) begin
            req_ready[grant_id_s] = 1'b1;
            if (grant_id_s == ID_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_id_s + ID_W'(1);
            end
        end else begin
            req_ready = '0;
        end
    end

    // Round-robin pointer moves only on a transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    mult_tree_pipe #(
        .ID_W (ID_W)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (grant_found_s),
        .in_id_i     (grant_id_s),
        .in_opnd_i   (grant_opnd_s),
        .out_valid_o (pipe_valid_s),
        .out_id_o    (pipe_id_s),
        .out_res_o   (pipe_res_s),
        .busy_o      (busy)
    );

    // Response demux: decode the returning ID to a one-hot strobe
    always_comb begin
        rsp_valid_d = '0;
        if (pipe_valid_s) begin
            rsp_valid_d[pipe_id_s] = 1'b1;
        end else begin
            rsp_valid_d = '0;
        end
    end

    // Registered response; ID and result hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (pipe_valid_s) begin
                rsp_id_q     <= pipe_id_s;
                rsp_result_q <= pipe_res_s;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

`ifdef MULT_ARB_STATS_EN
    logic [15:0] cnt_q [N_REQ];

    // Saturating per-requester grant counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_found_s && (grant_id_s == ID_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'h0001;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[16*i +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mult_tree_arbiter.sv
// Scoreboard bench for mult_tree_arbiter: a reference arbiter predicts grants, expected responses are queued and retired.
module tb_mult_tree_arbiter;

    localparam int N = 4;

    typedef struct {
        int id;
        int res;
        int due;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [4*N-1:0] req_a, req_b, req_c, req_d;
    logic [N-1:0]  rsp_valid;
    logic [1:0]    rsp_id;
    logic [7:0]    rsp_result;
    logic          busy;
`ifdef MULT_ARB_STATS_EN
    logic [16*N-1:0] grant_cnt;
`endif

    logic [3:0] a_v [N];
    logic [3:0] b_v [N];
    logic [3:0] c_v [N];
    logic [3:0] d_v [N];

    exp_t q[$];
    int   grants[$];
    int   rr_m;
    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   keep;

    mult_tree_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_d      (req_d),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef MULT_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[4*i +: 4] = a_v[i];
            req_b[4*i +: 4] = b_v[i];
            req_c[4*i +: 4] = c_v[i];
            req_d[4*i +: 4] = d_v[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_res(input int a, input int b, input int c, input int d);
        return (((a * b * b) * (c * d * d)) >> 16) & 255;
    endfunction

    task automatic set_op(input int i, input int a, input int b, input int c, input int d);
        a_v[i] = 4'(a); b_v[i] = 4'(b); c_v[i] = 4'(c); d_v[i] = 4'(d);
    endtask

    task automatic rand_op(input int i);
        set_op(i, $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    // One clock: check ready/response/busy at negedge, retire model state after the edge
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        logic exp_busy;
        exp_t e;
        @(negedge clk);
        g = -1;
        if (en) begin
            for (int j = 0; j < N; j++) begin
                int idx;
                idx = (rr_m + j) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (q.size() > 0 && q[0].due == cyc) begin
            check_val("rsp_valid", 32'(rsp_valid), 32'(1 << q[0].id));
            check_val("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check_val("rsp_result", 32'(rsp_result), 32'(q[0].res));
            void'(q.pop_front());
        end else begin
            check_val("rsp_idle", 32'(rsp_valid), 32'd0);
        end
        exp_busy = 1'b0;
        foreach (q[i]) if (q[i].due > cyc && q[i].due <= cyc + 3) exp_busy = 1'b1;
        check_val("busy", 32'(busy), 32'(exp_busy));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            e.id  = g;
            e.res = model_res(a_v[g], b_v[g], c_v[g], d_v[g]);
            e.due = cyc + 4;
            q.push_back(e);
            grants.push_back(g);
            rr_m = (g + 1) % N;
            if (keep) rand_op(g);
            else req_valid[g] = 1'b0;
        end
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; rr_m = 0; keep = 1'b0;
        rst = 1'b1; en = 1'b0; req_valid = '0;
        for (int i = 0; i < N; i++) set_op(i, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_val("rst_rsp_result", 32'(rsp_result), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Single max-operand request from req0: expect 0xAD
        set_op(0, 15, 15, 15, 15);
        req_valid[0] = 1'b1;
        step();
        check_val("t1_expected", 32'(q.size() > 0 ? q[q.size()-1].res : -1), 32'h0000_00AD);
        drain(5);

        // req2 alone, then three requesters back to back
        set_op(2, 2, 3, 4, 5);
        req_valid[2] = 1'b1;
        step();
        rand_op(0); rand_op(1); rand_op(3);
        req_valid = 4'b1011;
        drain(9);

        // All valid from a fresh reset: strict rotation
        rst = 1'b1; q.delete(); rr_m = 0;
        @(posedge clk); #1; rst = 1'b0;
        grants.delete();
        keep = 1'b1;
        for (int i = 0; i < N; i++) rand_op(i);
        req_valid = 4'b1111;
        drain(8);
        for (int i = 0; i < 8; i++)
            check_val("rotation", 32'(i < grants.size() ? grants[i] : -1), 32'(i % N));
        req_valid = '0;
        keep = 1'b0;
        drain(5);

        // en low stalls grants while in-flight ops still return
        rand_op(0); rand_op(2);
        req_valid[0] = 1'b1; step();
        req_valid[2] = 1'b1; step();
        en = 1'b0;
        rand_op(1);
        req_valid[1] = 1'b1;
        drain(5);
        en = 1'b1;
        step();
        drain(5);

        // Reset with three ops in flight
        keep = 1'b1;
        for (int i = 0; i < N; i++) rand_op(i);
        req_valid = 4'b0110;
        drain(3);
        rst = 1'b1;
        #1;
        check_val("rst_flight_busy", 32'(busy), 32'd0);
        check_val("rst_flight_rsp", 32'(rsp_valid), 32'd0);
        q.delete(); rr_m = 0;
        req_valid = 4'b1111;
        @(posedge clk); #1; rst = 1'b0;
        grants.delete();
        step();
        check_val("rst_rr_ptr", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
        req_valid = '0;
        drain(6);

`ifdef MULT_ARB_STATS_EN
        rst = 1'b1; q.delete(); rr_m = 0;
        @(posedge clk); #1; rst = 1'b0;
        check_val("cnt_clear", 32'(grant_cnt[63:48]), 32'd0);
        keep = 1'b1;
        req_valid = 4'b1000;
        drain(70000);
        req_valid = '0;
        keep = 1'b0;
        drain(5);
        check_val("cnt3_sat", 32'(grant_cnt[63:48]), 32'h0000_FFFF);
        check_val("cnt_others", 32'(grant_cnt[47:0] != 48'd0), 32'd0);
`endif

        check_val("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
